// File: rtl/gfx_cmd_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gfx_cmd_issuer_pkg
// Description : Shared types and constants for the graphics command issuer.
// Revision    : 1.0 - initial release
// ============================================================================
package gfx_cmd_issuer_pkg;

  localparam int GFX_CMD_W   = 24;
  localparam int GAP_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_GAP        = 2'd2,
    ST_WAIT_FRAME = 2'd3
  } gfx_state_e;

  typedef struct packed {
    logic                 defer;
    logic [GFX_CMD_W-1:0] data;
  } gfx_cmd_t;

endpackage
`default_nettype wire

// File: rtl/gfx_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gfx_cmd_fifo
// Description : Synchronous show-ahead FIFO with wrap-bit pointers and
//               registered full/empty/level flags.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_cmd_fifo
  import gfx_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = GFX_CMD_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wptr;
  logic [c_aw:0]    r_rptr;
  logic [c_aw:0]    r_level;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [c_aw:0]    w_wptr_nxt;
  logic [c_aw:0]    w_rptr_nxt;

  // A write while full is refused even if a read frees a slot this cycle.
  assign w_push     = wr_en && !r_full;
  assign w_pop      = rd_en && !r_empty;
  assign w_wptr_nxt = r_wptr + {{c_aw{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{c_aw{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_aw-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_level <= w_wptr_nxt - w_rptr_nxt;
      r_full  <= (w_wptr_nxt[c_aw] != w_rptr_nxt[c_aw]) &&
                 (w_wptr_nxt[c_aw-1:0] == w_rptr_nxt[c_aw-1:0]);
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
    end
  end

  assign rd_data = r_mem[r_rptr[c_aw-1:0]];
  assign full    = r_full;
  assign empty   = r_empty;
  assign level   = r_level;

endmodule
`default_nettype wire

// File: rtl/gfx_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : gfx_cmd_issuer
// Description : Buffers CPU graphics commands and replays them as spaced
//               start pulses, holding deferred ones for the frame interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_cmd_issuer
  import gfx_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GFX_CMD_W-1:0]   cpu_wdata,
  input  logic                   cpu_we,
  input  logic                   cpu_defer,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  input  logic                   ovf_clr,
  input  logic                   frame_irq,
  input  logic                   gpu_busy,
  output logic [GFX_CMD_W-1:0]   gfx_in,
  output logic                   gfx_start
);

  localparam logic [3:0] c_gap_last = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  gfx_state_e           r_state;
  logic [3:0]           r_gap_cnt;
  logic                 r_win;
  logic                 r_ovf;
  logic                 r_start;
  logic [GFX_CMD_W-1:0] r_gfx_in;

  gfx_cmd_t             w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;

  assign w_pop = (r_state == ST_ISSUE);

  gfx_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (GFX_CMD_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cpu_we),
    .wr_data ({cpu_defer, cpu_wdata}),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= 4'd0;
      r_win     <= 1'b0;
      r_start   <= 1'b0;
      r_gfx_in  <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_empty) begin
            r_win <= 1'b0;
          end else if (!gpu_busy) begin
            if (!w_head.defer || r_win) begin
              r_state <= ST_ISSUE;
            end else begin
              r_state <= ST_WAIT_FRAME;
            end
          end
        end
        ST_WAIT_FRAME: begin
          if (frame_irq) begin
            r_win   <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_start  <= 1'b1;
          r_gfx_in <= w_head.data;
          // A normal command closes the vblank window for later deferred ones.
          if (!w_head.defer) begin
            r_win <= 1'b0;
          end
          if (GAP == 0) begin
            r_state <= ST_IDLE;
          end else begin
            r_state   <= ST_GAP;
            r_gap_cnt <= c_gap_last;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A dropped push outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (cpu_we && w_full) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign full      = w_full;
  assign ovf       = r_ovf;
  assign gfx_in    = r_gfx_in;
  assign gfx_start = r_start;

endmodule
`default_nettype wire

// File: tb/tb_gfx_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfx_cmd_issuer
// Description : Self-checking bench for gfx_cmd_issuer (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_cmd_issuer;
  import gfx_cmd_issuer_pkg::*;

  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_defer = 1'b0;
  logic        full;
  logic [4:0]  level;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic        frame_irq = 1'b0;
  logic        gpu_busy = 1'b0;
  logic [23:0] gfx_in;
  logic        gfx_start;

  always #5 clk = ~clk;

  gfx_cmd_issuer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_defer (cpu_defer),
    .full      (full),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .frame_irq (frame_irq),
    .gpu_busy  (gpu_busy),
    .gfx_in    (gfx_in),
    .gfx_start (gfx_start)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          pulse_cyc[$];
  logic [23:0] pulse_dat[$];

  // Inputs as seen by the most recent rising edge
  logic        a_we, a_def, a_clr;
  logic [23:0] a_dat;

  // Reference model: a plain queue of accepted commands
  bit          chk_en = 1'b0;
  logic [24:0] m_q[$];
  logic        m_ovf = 1'b0;
  int          m_last = -1;
  bit          full_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    a_we  = cpu_we;
    a_def = cpu_defer;
    a_dat = cpu_wdata;
    a_clr = ovf_clr;
  end

  always @(negedge clk) begin
    if (gfx_start === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(gfx_in);
    end
    if (chk_en) begin
      full_b = (m_q.size() == DEPTH);
      if (gfx_start === 1'b1) begin
        check("rand_issue_nonempty", 32'(m_q.size() != 0), 32'd1);
        if (m_q.size() != 0) begin
          check("rand_issue_data", 32'(gfx_in), 32'(m_q[0][23:0]));
          void'(m_q.pop_front());
        end
        if (m_last >= 0) begin
          n_tests++;
          if (cyc - m_last < GAP + 2) begin
            n_fail++;
            $display("FAIL rand_spacing: got %0d cycles, required >= %0d", cyc - m_last, GAP + 2);
          end
        end
        m_last = cyc;
      end
      if (a_we && full_b) m_ovf = 1'b1;
      else if (a_clr)     m_ovf = 1'b0;
      if (a_we && !full_b) m_q.push_back({a_def, a_dat});
      check("rand_level", 32'(level), 32'(m_q.size()));
      check("rand_full", 32'(full), 32'(m_q.size() == DEPTH));
      check("rand_ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic push(input logic [23:0] d, input logic df, output int e);
    cpu_we    = 1'b1;
    cpu_wdata = d;
    cpu_defer = df;
    @(negedge clk);
    e         = cyc;
    cpu_we    = 1'b0;
    cpu_defer = 1'b0;
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_dat.delete();
  endtask

  typedef struct {
    logic [23:0] data;
    logic        defer;
    int          exp_off;
  } vec_t;

  vec_t vt[5];

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, e0, b, m;
    bit found;
    logic [23:0] dw[4];

    vt[0] = '{24'h100001, 1'b0, 2};
    vt[1] = '{24'h200002, 1'b0, 6};
    vt[2] = '{24'h300003, 1'b0, 10};
    vt[3] = '{24'h400004, 1'b0, 14};
    vt[4] = '{24'h500005, 1'b0, 18};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gfx_start", 32'(gfx_start), 0);
    check("rst_gfx_in", 32'(gfx_in), 0);
    check("rst_full", 32'(full), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single push
    clear_log();
    push(24'hA51234, 1'b0, e);
    check("single_level_1", 32'(level), 1);
    repeat (12) @(negedge clk);
    check("single_count", 32'(pulse_cyc.size()), 1);
    if (pulse_cyc.size() >= 1) begin
      check("single_latency", 32'(pulse_cyc[0] - e), 2);
      check("single_data", 32'(pulse_dat[0]), 32'hA51234);
    end
    check("single_level_0", 32'(level), 0);
    check("single_hold", 32'(gfx_in), 32'hA51234);

    // Back-to-back table
    clear_log();
    e0 = 0;
    for (int i = 0; i < 5; i++) begin
      push(vt[i].data, vt[i].defer, e);
      if (i == 0) e0 = e;
    end
    repeat (30) @(negedge clk);
    check("b2b_count", 32'(pulse_cyc.size()), 5);
    for (int i = 0; i < 5; i++) begin
      if (pulse_cyc.size() > i) begin
        check("b2b_offset", 32'(pulse_cyc[i] - e0), 32'(vt[i].exp_off));
        check("b2b_data", 32'(pulse_dat[i]), 32'(vt[i].data));
      end
    end

    // Overflow with set-wins on the dropped push
    clear_log();
    gpu_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) ovf_clr = 1'b1;
      push(24'h300000 + 24'(i), 1'b0, e);
      ovf_clr = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("ovf_full", 32'(full), 1);
    check("ovf_level", 32'(level), 16);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_no_pulse", 32'(pulse_cyc.size()), 0);
    gpu_busy = 1'b0;
    repeat (16 * 4 + 10) @(negedge clk);
    check("ovf_drain_count", 32'(pulse_cyc.size()), 16);
    for (int i = 0; i < 16; i++) begin
      if (pulse_dat.size() > i)
        check("ovf_drain_data", 32'(pulse_dat[i]), 32'h300000 + 32'(i));
    end
    check("ovf_drain_level", 32'(level), 0);
    check("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);

    // Stray frame_irq while idle, then deferred burst
    clear_log();
    frame_irq = 1'b1;
    @(negedge clk);
    frame_irq = 1'b0;
    repeat (2) @(negedge clk);
    dw[0] = 24'hD10001; dw[1] = 24'hD20002; dw[2] = 24'hE10003; dw[3] = 24'hD30004;
    push(dw[0], 1'b1, e);
    push(dw[1], 1'b1, e);
    push(dw[2], 1'b0, e);
    push(dw[3], 1'b1, e);
    repeat (10) @(negedge clk);
    check("defer_no_pulse", 32'(pulse_cyc.size()), 0);
    check("defer_level", 32'(level), 4);
    frame_irq = 1'b1;
    @(negedge clk);
    m = cyc;
    frame_irq = 1'b0;
    repeat (20) @(negedge clk);
    check("defer_burst_count", 32'(pulse_cyc.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (pulse_cyc.size() > i) begin
        check("defer_burst_time", 32'(pulse_cyc[i] - m), 32'(1 + 4 * i));
        check("defer_burst_data", 32'(pulse_dat[i]), 32'(dw[i]));
      end
    end
    frame_irq = 1'b1;
    @(negedge clk);
    m = cyc;
    frame_irq = 1'b0;
    repeat (8) @(negedge clk);
    check("defer_d3_count", 32'(pulse_cyc.size()), 4);
    if (pulse_cyc.size() >= 4) begin
      check("defer_d3_time", 32'(pulse_cyc[3] - m), 1);
      check("defer_d3_data", 32'(pulse_dat[3]), 32'(dw[3]));
    end

    // Busy stall
    clear_log();
    gpu_busy = 1'b1;
    for (int i = 0; i < 3; i++) push(24'h700000 + 24'(i), 1'b0, e);
    repeat (5) @(negedge clk);
    check("busy_no_pulse", 32'(pulse_cyc.size()), 0);
    gpu_busy = 1'b0;
    b = cyc;
    repeat (16) @(negedge clk);
    check("busy_count", 32'(pulse_cyc.size()), 3);
    if (pulse_cyc.size() >= 1) check("busy_release_latency", 32'(pulse_cyc[0] - b), 2);

    // Reset mid-burst
    gpu_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(24'h800000 + 24'(i), 1'b0, e);
    gpu_busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (gfx_start === 1'b1) found = 1'b1;
    end
    check("rstmid_pulse_seen", 32'(found), 1);
    check("rstmid_level_before", 32'(level), 7);
    #2 rst = 1'b0;
    #1;
    check("rstmid_gfx_start", 32'(gfx_start), 0);
    check("rstmid_gfx_in", 32'(gfx_in), 0);
    check("rstmid_level", 32'(level), 0);
    check("rstmid_full", 32'(full), 0);
    check("rstmid_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    check("rstmid_no_pulse", 32'(pulse_cyc.size()), 0);
    check("rstmid_level_after", 32'(level), 0);

    // Randomized run against the queue model
    m_q.delete();
    m_ovf  = 1'b0;
    m_last = -1;
    chk_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cpu_we    = ($urandom_range(0, 2) == 0);
      cpu_wdata = 24'($urandom);
      cpu_defer = ($urandom_range(0, 3) == 0);
      gpu_busy  = ($urandom_range(0, 4) == 0);
      frame_irq = ($urandom_range(0, 15) == 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    cpu_we   = 1'b0;
    gpu_busy = 1'b0;
    ovf_clr  = 1'b0;
    for (int i = 0; i < 3000 && m_q.size() != 0; i++) begin
      frame_irq = (i % 8 == 0);
      @(negedge clk);
    end
    frame_irq = 1'b0;
    repeat (GAP + 4) @(negedge clk);
    check("rand_drained", 32'(m_q.size()), 0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
